// File: rtl/alu_wb_sequencer_pkg.sv
// alu_wb_sequencer_pkg: register offsets, sequencer states and ALU opcodes shared by the sequencer and its bench
package alu_wb_sequencer_pkg;

    localparam logic [31:0] OFF_A      = 32'd0;
    localparam logic [31:0] OFF_IO     = 32'd4;
    localparam logic [31:0] OFF_RES_LO = 32'd8;
    localparam logic [31:0] OFF_B      = 32'd12;
    localparam logic [31:0] OFF_OP     = 32'd16;
    localparam logic [31:0] OFF_RES_HI = 32'd20;

    typedef enum logic [2:0] {
        IDLE, WR_A, WR_B, WR_OP, SETTLE, RD_LO, RD_HI, DONE
    } state_e;

    typedef enum logic [3:0] {
        OP_NOT  = 4'b0000,
        OP_AND  = 4'b0001,
        OP_OR   = 4'b0010,
        OP_XOR  = 4'b0011,
        OP_NOR  = 4'b0100,
        OP_ADD  = 4'b0101,
        OP_SUB  = 4'b0110,
        OP_XNOR = 4'b0111,
        OP_MUL  = 4'b1000,
        OP_DIV  = 4'b1001,
        OP_SHL  = 4'b1010,
        OP_SHR  = 4'b1011
    } op_e;

endpackage

// File: rtl/alu_wb_sequencer_if.sv
// alu_wb_sequencer_if: job stream, result stream and Wishbone master bus of the sequencer
interface alu_wb_sequencer_if;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_a;
    logic [31:0] in_b;
    logic [3:0]  in_op;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] out_result;
    logic        out_err;
    logic        o_wb_cyc;
    logic        o_wb_stb;
    logic        o_wb_we;
    logic [31:0] o_wb_addr;
    logic [31:0] o_wb_data;
    logic        i_wb_ack;
    logic        i_wb_stall;
    logic [31:0] i_wb_data;

    modport master (
        input  in_valid, in_a, in_b, in_op, out_ready, i_wb_ack, i_wb_stall, i_wb_data,
        output in_ready, out_valid, out_result, out_err,
        output o_wb_cyc, o_wb_stb, o_wb_we, o_wb_addr, o_wb_data
    );

    modport slave (
        output in_valid, in_a, in_b, in_op, out_ready, i_wb_ack, i_wb_stall, i_wb_data,
        input  in_ready, out_valid, out_result, out_err,
        input  o_wb_cyc, o_wb_stb, o_wb_we, o_wb_addr, o_wb_data
    );
endinterface

// File: rtl/alu_wb_sequencer_wb_single_xfer.sv
// wb_single_xfer: one pipelined Wishbone transaction per start pulse.
// ALU_SEQ_TIMEOUT_EN adds an ack-wait limit of TIMEOUT_CYCLES.
module wb_single_xfer #(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start_i,
    input  logic        we_i,
    input  logic [31:0] addr_i,
    input  logic [31:0] wdata_i,
    output logic        done_o,
    output logic        timeout_o,
    output logic [31:0] rdata_o,
    output logic        cyc_o,
    output logic        stb_o,
    output logic        we_o,
    output logic [31:0] addr_o,
    output logic [31:0] wdata_o,
    input  logic        ack_i,
    input  logic        stall_i,
    input  logic [31:0] rdata_i
);
    logic        cyc_q, stb_q, we_q, end_w;
    logic [31:0] addr_q, wdata_q;

    assign done_o  = cyc_q & ack_i;
    assign rdata_o = rdata_i;
    assign end_w   = done_o | timeout_o;
    assign cyc_o   = cyc_q;
    assign stb_o   = stb_q;
    assign we_o    = we_q;
    assign addr_o  = addr_q;
    assign wdata_o = wdata_q;

`ifdef ALU_SEQ_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    logic [TW-1:0] tcnt_q;
    assign timeout_o = cyc_q & ~ack_i & (tcnt_q == TW'(TIMEOUT_CYCLES - 1));
    always_ff @(posedge clk or negedge reset)
        if (!reset) tcnt_q <= '0;
        else        tcnt_q <= start_i ? '0 : tcnt_q + TW'(cyc_q);
`else
    logic unused_timeout;
    assign unused_timeout = TIMEOUT_CYCLES != 0;
    assign timeout_o = 1'b0;
`endif

    // A start coinciding with the previous ack re-raises cyc with no idle gap.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cyc_q   <= 1'b0;
            stb_q   <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
        end else if (start_i) begin
            cyc_q   <= 1'b1;
            stb_q   <= 1'b1;
            we_q    <= we_i;
            addr_q  <= addr_i;
            wdata_q <= wdata_i;
        end else begin
            if ((stb_q & ~stall_i) | end_w) stb_q <= 1'b0;
            if (end_w) cyc_q <= 1'b0;
        end
    end
endmodule

// File: rtl/alu_wb_sequencer.sv
// alu_wb_sequencer: drives the ALU peripheral over Wishbone for each valid/ready job.
// ALU_SEQ_TIMEOUT_EN enables aborting a job whose slave never acks (reported on out_err).
module alu_wb_sequencer
    import alu_wb_sequencer_pkg::*;
#(
    parameter logic [31:0] BASE_ADDRESS   = 32'h3000_0000,
    parameter int          SETTLE_CYCLES  = 2,
    parameter int          TIMEOUT_CYCLES = 255
) (
    input logic               clk,
    input logic               reset,
    alu_wb_sequencer_if.master bus
);
    localparam int CW = SETTLE_CYCLES > 1 ? $clog2(SETTLE_CYCLES) : 1;

    state_e        state_q, state_d;
    logic [31:0]   b_q;
    logic [3:0]    op_q;
    logic [CW-1:0] cnt_q;
    logic [63:0]   res_q;
    logic          err_q, out_valid_q, in_ready_q, accept;
    logic          x_start, x_we, x_done, x_timeout;
    logic [31:0]   x_addr, x_wdata, x_rdata;

    assign accept         = bus.in_valid & in_ready_q;
    assign bus.in_ready   = in_ready_q;
    assign bus.out_valid  = out_valid_q;
    assign bus.out_result = res_q;
    assign bus.out_err    = err_q;

    // Next bus transaction is launched on the same edge the FSM enters its state.
    always_comb begin
        state_d = state_q;
        x_start = 1'b0;
        x_we    = 1'b1;
        x_addr  = BASE_ADDRESS + OFF_A;
        x_wdata = bus.in_a;
        case (state_q)
            IDLE:   if (accept) begin
                state_d = WR_A;
                x_start = 1'b1;
            end
            WR_A:   if (x_done) begin
                state_d = WR_B;
                x_start = 1'b1;
                x_addr  = BASE_ADDRESS + OFF_B;
                x_wdata = b_q;
            end
            WR_B:   if (x_done) begin
                state_d = WR_OP;
                x_start = 1'b1;
                x_addr  = BASE_ADDRESS + OFF_OP;
                x_wdata = {28'b0, op_q};
            end
            WR_OP:  if (x_done) state_d = SETTLE;
            SETTLE: if (cnt_q == '0) begin
                state_d = RD_LO;
                x_start = 1'b1;
                x_we    = 1'b0;
                x_addr  = BASE_ADDRESS + OFF_RES_LO;
            end
            RD_LO:  if (x_done) begin
                state_d = RD_HI;
                x_start = 1'b1;
                x_we    = 1'b0;
                x_addr  = BASE_ADDRESS + OFF_RES_HI;
            end
            RD_HI:  if (x_done) state_d = DONE;
            DONE:   if (bus.out_ready) state_d = IDLE;
        endcase
        if (x_timeout) state_d = DONE;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            b_q         <= '0;
            op_q        <= '0;
            cnt_q       <= '0;
            res_q       <= '0;
            err_q       <= 1'b0;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            in_ready_q  <= state_d == IDLE;
            out_valid_q <= state_d == DONE;
            cnt_q       <= state_q == SETTLE ? cnt_q - CW'(1) : CW'(SETTLE_CYCLES - 1);
            if (accept) begin
                b_q   <= bus.in_b;
                op_q  <= bus.in_op;
                res_q <= '0;
                err_q <= 1'b0;
            end
            if (x_done && state_q == RD_LO) res_q[31:0]  <= x_rdata;
            if (x_done && state_q == RD_HI) res_q[63:32] <= x_rdata;
            if (x_timeout) begin
                res_q <= '0;
                err_q <= 1'b1;
            end
        end
    end

    wb_single_xfer #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_xfer (
        .clk       (clk),
        .reset     (reset),
        .start_i   (x_start),
        .we_i      (x_we),
        .addr_i    (x_addr),
        .wdata_i   (x_wdata),
        .done_o    (x_done),
        .timeout_o (x_timeout),
        .rdata_o   (x_rdata),
        .cyc_o     (bus.o_wb_cyc),
        .stb_o     (bus.o_wb_stb),
        .we_o      (bus.o_wb_we),
        .addr_o    (bus.o_wb_addr),
        .wdata_o   (bus.o_wb_data),
        .ack_i     (bus.i_wb_ack),
        .stall_i   (bus.i_wb_stall),
        .rdata_i   (bus.i_wb_data)
    );
endmodule

// File: doc/alu_wb_sequencer.md
# alu_wb_sequencer

Wishbone master that drives the button/LED ALU peripheral from a simple valid/ready job stream. For each job it writes operand A, operand B and the opcode, waits for the ALU result register to settle, then reads the result low and high words. It returns the 64-bit result on a valid/ready output port. It sits directly upstream of the ALU peripheral on the user-area Wishbone bus, replacing firmware polling.

## Interface
- `BASE_ADDRESS`, default 32'h3000_0000: ALU peripheral base address.
- `SETTLE_CYCLES`, default 2: idle cycles between opcode-write ack and result read; minimum 1.
- `TIMEOUT_CYCLES`, default 255: maximum cycles a transaction waits for ack (only with the timeout feature).
- `clk` in 1: single clock.
- `reset` in 1: reset, asynchronous assert, active-low.
- `in_valid` in 1: job present.
- `in_ready` out 1: job accepted when `in_valid & in_ready`.
- `in_a` in 32: operand A.
- `in_b` in 32: operand B.
- `in_op` in 4: ALU opcode.
- `out_valid` out 1: result present.
- `out_ready` in 1: result consumed when `out_valid & out_ready`.
- `out_result` out 64: {high word, low word}.
- `out_err` out 1: job aborted by timeout; qualified by `out_valid`.
- `o_wb_cyc`, `o_wb_stb`, `o_wb_we` out 1 each: Wishbone master controls.
- `o_wb_addr` out 32: bus address.
- `o_wb_data` out 32: write data.
- `i_wb_ack`, `i_wb_stall` in 1 each: slave response and stall.
- `i_wb_data` in 32: read data.

## Operation
- Address offsets from `BASE_ADDRESS`: A +0, B +12, opcode +16, result low +8, result high +20.
- States: IDLE → WR_A → WR_B → WR_OP → SETTLE → RD_LO → RD_HI → DONE → IDLE.
- IDLE: `in_ready`=1 only in IDLE with `out_valid`=0. On accept, latch a/b/op and go to WR_A.
- Each bus state is one pipelined single transaction:
  - Raise `cyc` and `stb` on state entry.
  - Hold `stb` while `i_wb_stall`=1. Drop `stb` after the first cycle with `stb & !stall`.
  - Keep `cyc` until `i_wb_ack`. Drop `cyc` in the ack cycle and advance next cycle.
- Writes: `we`=1, `o_wb_data` = A, B, or {28'b0, op}.
- Reads: `we`=0. Capture `i_wb_data` on ack into result [31:0] (RD_LO) or [63:32] (RD_HI).
- Acks arriving while `cyc`=0 are ignored.
- SETTLE: down-counter loaded with `SETTLE_CYCLES`; leave at zero.
- DONE: set `out_valid`. Hold `out_result`/`out_err` stable until `out_ready`, then clear `out_valid` and return to IDLE.
- Reset values: all outputs 0, state IDLE, result/err 0. Asserting `reset` mid-transaction drops `cyc`/`stb` immediately and discards the job.

## Timing
- Zero stall, ack one cycle after `stb`: each transaction takes 2 cycles.
- Accept at cycle 0: A in 1–2, B in 3–4, OP in 5–6, SETTLE 7–8, RD_LO 9–10, RD_HI 11–12, `out_valid`=1 at 13.
- Each stall cycle adds one cycle. Ack delay beyond one cycle adds one cycle per cycle.
- Next job can be accepted the cycle after the `out_valid & out_ready` handshake.

## Configuration
- `ALU_SEQ_TIMEOUT_EN` defined:
  - A counter runs while `cyc`=1, cleared on state entry.
  - At `TIMEOUT_CYCLES` without ack: drop `cyc`/`stb`, set `out_err`=1, `out_result`=0, go to DONE.
- Undefined: no counter; the sequencer waits indefinitely for ack; `out_err` is tied 0.

## Structure
- Shared package holds:
  - address offset constants (0, 4, 8, 12, 16, 20);
  - the state enum;
  - opcode constants (NOT 0000 through SHR 1011).
- One sub-module, `wb_single_xfer`: single-transaction pipelined master. It takes start/we/addr/wdata and returns done/rdata/timeout, and holds the stb/cyc/stall/ack rules and the optional timeout counter. The top FSM sequences it.

## Test plan
- Add: a=5, b=7, op=0101, behavioural ALU slave → `out_valid` at cycle 13, result 64'h0000_0000_0000_000C, err 0.
- Multiply: a=32'hFFFF_FFFF, b=2, op=1000 → result 64'h0000_0001_FFFF_FFFE.
- Stall: `i_wb_stall`=1 for 3 cycles during WR_B → `stb` and address +12 held, `out_valid` at cycle 16.
- Backpressure: `out_ready`=0 for 5 cycles → result stable, `in_ready`=0, second job accepted the cycle after the handshake.
- Timeout (macro defined): slave never acks WR_A → `cyc` drops after 255 cycles, `out_err`=1, result 0. Macro undefined: no completion after 1000 cycles.
- Reset: assert `reset` during RD_LO → `cyc`/`stb`/`out_valid` 0 immediately. After release the state is IDLE, `in_ready`=1, and the next job completes normally.
